icache_refill_ctrl: RTL and testbench

Sequences L1 instruction-cache line refills between the fetch stage and the lower memory hierarchy. Captures the fetch stage's miss indication and address, issues a line-aligned request to memory with a request/grant handshake, and assembles the returned data beats into one cache line. It then drives the cache write port (`wrEnable`/`wrAddr`/`instBlock`) for exactly one cycle. Optionally arbitrates a next-line prefetch against demand misses.

---
 rtl/icache_refill_ctrl_if.sv | 37 +++
 rtl/icache_refill_ctrl.sv | 161 ++++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_refill_ctrl_if.sv
// Fetch-side and memory-side signal bundle for the L1I refill controller.
// The controller takes the slave view; the fetch/memory model drives master.
interface icache_refill_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
);
  logic              miss_i;
  logic [ADDR_W-1:0] missAddr_i;
  logic              flush_i;
  logic              memReq_o;
  logic [ADDR_W-1:0] memAddr_o;
  logic              memGnt_i;
  logic              memRespValid_i;
  logic [BEAT_W-1:0] memRespData_i;
  logic              wrEnable_o;
  logic [ADDR_W-1:0] wrAddr_o;
  logic [LINE_W-1:0] instBlock_o;
  logic              busy_o;
  logic              pfActive_o;

  modport slave (
    input  miss_i, missAddr_i, flush_i,
    input  memGnt_i, memRespValid_i, memRespData_i,
    output memReq_o, memAddr_o,
    output wrEnable_o, wrAddr_o, instBlock_o,
    output busy_o, pfActive_o
  );

  modport master (
    output miss_i, missAddr_i, flush_i,
    output memGnt_i, memRespValid_i, memRespData_i,
    input  memReq_o, memAddr_o,
    input  wrEnable_o, wrAddr_o, instBlock_o,
    input  busy_o, pfActive_o
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// L1I line refill sequencer: miss capture, memory request/grant, beat assembly.
// Define ICACHE_NEXT_LINE_PREFETCH_EN to build in next-line prefetch.
module icache_refill_ctrl #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input logic clk,
  input logic reset,
  icache_refill_ctrl_if.slave bus
);
  localparam int LB    = LINE_W / 8;
  localparam int BEATS = LINE_W / BEAT_W;
  localparam int OFF_W = $clog2(LB);
  localparam int BC_W  = $clog2(BEATS);

  typedef enum logic [1:0] {IDLE, REQ, DATA, WRITE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] line_addr_q, line_addr_d;
  logic              is_pf_q, is_pf_d;
  logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [LINE_W-1:0] inst_block_q, inst_block_d;
  logic              after_wr_q, after_wr_d;
  logic [ADDR_W-1:0] miss_line;
  logic              sup;
  logic              busy;
  logic              pf_set, pf_clr;
  logic              unused_lo;

  assign miss_line = {bus.missAddr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign unused_lo = ^bus.missAddr_i[OFF_W-1:0];
  // The tag array lags one cycle behind the write port.
  assign sup  = after_wr_q && (miss_line == line_addr_q);
  assign busy = (state_q != IDLE);

`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pf_addr_q, pf_addr_d;

  always_comb begin
    pend_d    = pend_q;
    pf_addr_d = pf_addr_q;
    if (pf_clr) pend_d = 1'b0;
    if (pf_set) begin
      pend_d    = 1'b1;
      pf_addr_d = line_addr_q + ADDR_W'(LB);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q    <= 1'b0;
      pf_addr_q <= '0;
    end else begin
      pend_q    <= pend_d;
      pf_addr_q <= pf_addr_d;
    end
  end

  assign bus.pfActive_o = busy && is_pf_q;
`else
  logic              pend_q;
  logic [ADDR_W-1:0] pf_addr_q;
  logic              unused_pf;

  assign pend_q         = 1'b0;
  assign pf_addr_q      = '0;
  assign unused_pf      = ^{pf_set, pf_clr, is_pf_q};
  assign bus.pfActive_o = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    line_addr_d  = line_addr_q;
    is_pf_d      = is_pf_q;
    beat_cnt_d   = beat_cnt_q;
    line_d       = line_q;
    wr_addr_d    = wr_addr_q;
    inst_block_d = inst_block_q;
    after_wr_d   = 1'b0;
    pf_set       = 1'b0;
    pf_clr       = bus.flush_i && (state_q == IDLE);
    unique case (state_q)
      IDLE: begin
        if (bus.miss_i && !sup) begin
          line_addr_d = miss_line;
          is_pf_d     = 1'b0;
          state_d     = REQ;
        end else if (pend_q && !bus.flush_i) begin
          line_addr_d = pf_addr_q;
          is_pf_d     = 1'b1;
          pf_clr      = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (bus.memGnt_i) begin
          state_d    = DATA;
          beat_cnt_d = '0;
        end
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
        else if (is_pf_q && bus.miss_i) begin
          line_addr_d = miss_line;
          is_pf_d     = 1'b0;
        end else if (is_pf_q && bus.flush_i) begin
          state_d = IDLE;
        end
`endif
      end
      DATA: begin
        if (bus.memRespValid_i) begin
          line_d[int'(beat_cnt_q)*BEAT_W +: BEAT_W] = bus.memRespData_i;
          beat_cnt_d = beat_cnt_q + BC_W'(1);
          if (beat_cnt_q == BC_W'(BEATS-1)) begin
            state_d      = WRITE;
            wr_addr_d    = line_addr_q;
            inst_block_d = line_d;
          end
        end
      end
      WRITE: begin
        state_d    = IDLE;
        after_wr_d = 1'b1;
        pf_set     = !is_pf_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      line_addr_q  <= '0;
      is_pf_q      <= 1'b0;
      beat_cnt_q   <= '0;
      line_q       <= '0;
      wr_addr_q    <= '0;
      inst_block_q <= '0;
      after_wr_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_addr_q  <= line_addr_d;
      is_pf_q      <= is_pf_d;
      beat_cnt_q   <= beat_cnt_d;
      line_q       <= line_d;
      wr_addr_q    <= wr_addr_d;
      inst_block_q <= inst_block_d;
      after_wr_q   <= after_wr_d;
    end
  end

  assign bus.memReq_o    = (state_q == REQ);
  assign bus.memAddr_o   = line_addr_q;
  assign bus.wrEnable_o  = (state_q == WRITE);
  assign bus.wrAddr_o    = wr_addr_q;
  assign bus.instBlock_o = inst_block_q;
  assign bus.busy_o      = busy;
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl with a transaction-level scoreboard.
// Prefetch scenarios run only when ICACHE_NEXT_LINE_PREFETCH_EN is defined.
module tb_icache_refill_ctrl;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int BW = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  icache_refill_ctrl_if #(.ADDR_W(AW), .LINE_W(LW), .BEAT_W(BW)) bus();

  icache_refill_ctrl #(.ADDR_W(AW), .LINE_W(LW), .BEAT_W(BW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [LW-1:0] d;
  } wr_t;

  wr_t           wq[$];
  wr_t           e;
  logic [AW-1:0] exp_req_addr = '0;
  logic          exp_pf = 1'b0;
  int            nvec = 0;
  int            nerr = 0;
  int            cyc = 0;
  int            c0 = 0;
  int            cyc_we = 0;
  int            wr_cnt = 0;
  int            wr_exp = 0;
  logic          mon_en = 1'b0;
  logic          prev_we = 1'b0;
  logic [AW-1:0] last_wa = '0;
  logic [LW-1:0] last_line = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [LW-1:0] got,
                     input logic [LW-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return a & ~(AW'(LW/8) - 1);
  endfunction

  // Scoreboard: requests and writes checked every cycle against the model.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (bus.memReq_o) begin
        chk("memAddr", bus.memAddr_o, exp_req_addr);
        chk("pfActive", bus.pfActive_o, exp_pf);
      end
      if (!bus.busy_o)
        chk("idle_outputs", {bus.memReq_o, bus.wrEnable_o, bus.pfActive_o}, 3'b000);
      if (bus.wrEnable_o) begin
        cyc_we = cyc;
        wr_cnt++;
        chk("single_strobe", prev_we, 1'b0);
        if (wq.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_write: got addr %0h want no write", bus.wrAddr_o);
        end else begin
          e = wq.pop_front();
          chk("wrAddr", bus.wrAddr_o, e.a);
          chk("instBlock", bus.instBlock_o, e.d);
        end
        last_wa   = bus.wrAddr_o;
        last_line = bus.instBlock_o;
      end
      prev_we = bus.wrEnable_o;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_check(input string t);
    chk({t, "_memReq"}, bus.memReq_o, 0);
    chk({t, "_memAddr"}, bus.memAddr_o, 0);
    chk({t, "_wrEnable"}, bus.wrEnable_o, 0);
    chk({t, "_wrAddr"}, bus.wrAddr_o, 0);
    chk({t, "_instBlock"}, bus.instBlock_o, 0);
    chk({t, "_busy"}, bus.busy_o, 0);
    chk({t, "_pfActive"}, bus.pfActive_o, 0);
  endtask

  task automatic start_miss(input logic [AW-1:0] a);
    exp_req_addr   = align(a);
    exp_pf         = 1'b0;
    bus.miss_i     = 1'b1;
    bus.missAddr_i = a;
    c0 = cyc;
    step();
    chk("req_after_miss", bus.memReq_o, 1);
  endtask

  task automatic serve(input int gw, input int gap,
                       input logic [BW-1:0] b0, input logic [BW-1:0] b1,
                       input logic [BW-1:0] b2, input logic [BW-1:0] b3,
                       input logic [AW-1:0] wa);
    logic [BW-1:0] bt [4];
    bt = '{b0, b1, b2, b3};
    repeat (gw) step();
    bus.memGnt_i = 1'b1;
    step();
    bus.memGnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (gap) step();
      bus.memRespValid_i = 1'b1;
      bus.memRespData_i  = bt[i];
      if (i == 3) begin
        wq.push_back('{wa, {b3, b2, b1, b0}});
        wr_exp++;
      end
      step();
      bus.memRespValid_i = 1'b0;
    end
  endtask

  // Holds the miss through the cycle after WRITE to exercise suppression.
  task automatic finish_demand(input logic [AW-1:0] a, input bit kill_pf);
    if (kill_pf) begin
      bus.flush_i = 1'b1;
    end else begin
      exp_req_addr = align(a) + AW'(LW/8);
      exp_pf       = 1'b1;
    end
    step();
    step();
    bus.miss_i  = 1'b0;
    bus.flush_i = 1'b0;
    chk(kill_pf ? "no_rerequest" : "pf_issued", bus.memReq_o, !kill_pf);
  endtask

  task automatic refill(input logic [AW-1:0] a, input int gw, input int gap,
                        input logic [BW-1:0] b0, input logic [BW-1:0] b1,
                        input logic [BW-1:0] b2, input logic [BW-1:0] b3);
    start_miss(a);
    serve(gw, gap, b0, b1, b2, b3, align(a));
    finish_demand(a, 1'b1);
    chk("miss_to_write", cyc_we - c0, 6 + gw + 4 * gap);
  endtask

  initial begin
    bus.miss_i         = 1'b0;
    bus.missAddr_i     = '0;
    bus.flush_i        = 1'b0;
    bus.memGnt_i       = 1'b0;
    bus.memRespValid_i = 1'b0;
    bus.memRespData_i  = '0;
    reset = 1'b1;
    #2;
    rst_check("por");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    step();

    // Basic demand refill, zero-wait grant, back-to-back beats
    start_miss(32'h0000_1234);
    chk("memAddr_lit", bus.memAddr_o, 32'h0000_1220);
    serve(0, 0, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
          64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 32'h0000_1220);
    finish_demand(32'h0000_1234, 1'b1);
    chk("latency_lit", cyc_we - c0, 6);
    chk("wrAddr_lit", last_wa, 32'h0000_1220);
    chk("beat0_lit", last_line[63:0], 64'h1111_1111_1111_1111);
    chk("beat3_lit", last_line[255:192], 64'h4444_4444_4444_4444);
    chk("wrAddr_hold", bus.wrAddr_o, 32'h0000_1220);

    refill(32'h8000_0047, 5, 2, 64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0002,
           64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
    refill(32'h0000_001F, 1, 1, 64'hA5A5_A5A5_5A5A_5A5A, 64'h0,
           64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001);
    chk("instBlock_hold", bus.instBlock_o[127:64], 64'h0);

`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
    // Prefetch of next line, then a demand miss steals the request
    start_miss(32'h0000_1220);
    serve(0, 0, 64'h11, 64'h22, 64'h33, 64'h44, 32'h0000_1220);
    finish_demand(32'h0000_1220, 1'b0);
    chk("pf_addr_lit", bus.memAddr_o, 32'h0000_1240);
    chk("pf_active_lit", bus.pfActive_o, 1);
    bus.miss_i     = 1'b1;
    bus.missAddr_i = 32'h0000_2000;
    step();
    exp_req_addr = 32'h0000_2000;
    exp_pf       = 1'b0;
    chk("steal_req", bus.memReq_o, 1);
    chk("steal_addr", bus.memAddr_o, 32'h0000_2000);
    chk("steal_pf", bus.pfActive_o, 0);
    serve(1, 0, 64'h55, 64'h66, 64'h77, 64'h88, 32'h0000_2000);
    finish_demand(32'h0000_2000, 1'b1);

    // Prefetch address wraps past the top of the address space
    start_miss(32'hFFFF_FFE5);
    serve(0, 1, 64'h99, 64'hAA, 64'hBB, 64'hCC, 32'hFFFF_FFE0);
    finish_demand(32'hFFFF_FFE5, 1'b0);
    chk("wrap_lit", bus.memAddr_o, 32'h0000_0000);
    serve(2, 0, 64'hD1, 64'hD2, 64'hD3, 64'hD4, 32'h0000_0000);
    step();
    step();
    chk("pf_no_chain", bus.busy_o, 0);

    // Flush drops an ungranted prefetch
    start_miss(32'h0000_6000);
    serve(0, 0, 64'h1, 64'h2, 64'h3, 64'h4, 32'h0000_6000);
    finish_demand(32'h0000_6000, 1'b0);
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    chk("flush_drop", bus.busy_o, 0);
    step();
    chk("flush_no_req", bus.memReq_o, 0);
`endif

    // Reset in the middle of a refill, then stray beats
    start_miss(32'h0000_3010);
    bus.memGnt_i = 1'b1;
    step();
    bus.memGnt_i       = 1'b0;
    bus.memRespValid_i = 1'b1;
    bus.memRespData_i  = 64'hBAD0_BAD0_BAD0_BAD0;
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    rst_check("mid");
    bus.miss_i = 1'b0;
    step();
    step();
    reset = 1'b0;
    repeat (4) step();
    bus.memRespValid_i = 1'b0;
    step();
    chk("no_write_after_reset", wr_cnt, wr_exp);
    chk("idle_after_reset", bus.busy_o, 0);
    chk("wq_empty", wq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
